// File: rtl/alu_ex_stage_if.sv
// ============================================================================
// alu_ex_stage_if : ID/EX -> EX/MEM handshake and data bundle for alu_ex_stage.
// Optional Overflow signal present when ALU_OVERFLOW_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              ID_Valid;
   logic [2:0]        ALU_Control;
   logic [DATA_W-1:0] Op_A;
   logic [DATA_W-1:0] Op_B;
   logic [REG_AW-1:0] Rd_In;
   logic              RegWrite_In;
   logic              MEM_Stall;
   logic              Flush;
   logic              ID_Ready;
   logic              EX_Valid;
   logic [DATA_W-1:0] ALU_Result;
   logic              Zero;
   logic [REG_AW-1:0] Rd_Out;
   logic              RegWrite_Out;
   logic              Illegal_Op;
`ifdef ALU_OVERFLOW_EN
   logic              Overflow;
`endif

   modport master (
      output ID_Valid, ALU_Control, Op_A, Op_B, Rd_In, RegWrite_In, MEM_Stall, Flush,
`ifdef ALU_OVERFLOW_EN
      input  Overflow,
`endif
      input  ID_Ready, EX_Valid, ALU_Result, Zero, Rd_Out, RegWrite_Out, Illegal_Op
   );

   modport slave (
      input  ID_Valid, ALU_Control, Op_A, Op_B, Rd_In, RegWrite_In, MEM_Stall, Flush,
`ifdef ALU_OVERFLOW_EN
      output Overflow,
`endif
      output ID_Ready, EX_Valid, ALU_Result, Zero, Rd_Out, RegWrite_Out, Illegal_Op
   );
endinterface

`default_nettype wire

// File: rtl/alu_ex_stage.sv
// ============================================================================
// alu_ex_stage : MIPS-32 execute-stage ALU with EX/MEM register, stall/flush.
// Optional trap-on-overflow via macro ALU_OVERFLOW_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module alu_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  wire             clk,
   input  wire             rst_n,
   alu_ex_stage_if.slave   bus
);
   localparam logic [2:0] c_op_and = 3'b000;
   localparam logic [2:0] c_op_or  = 3'b001;
   localparam logic [2:0] c_op_add = 3'b010;
   localparam logic [2:0] c_op_sub = 3'b110;
   localparam logic [2:0] c_op_slt = 3'b111;

   logic [DATA_W-1:0] result_c;
   logic              illegal_c;
   logic              ovf_c;
   logic [DATA_W-1:0] sum_c;
   logic [DATA_W-1:0] diff_c;

   logic              ex_valid_q,   ex_valid_d;
   logic [DATA_W-1:0] result_q,     result_d;
   logic              zero_q,       zero_d;
   logic [REG_AW-1:0] rd_q,         rd_d;
   logic              reg_write_q,  reg_write_d;
   logic              illegal_q,    illegal_d;
   logic              ovf_q,        ovf_d;

   assign sum_c  = bus.Op_A + bus.Op_B;
   assign diff_c = bus.Op_A - bus.Op_B;

   always_comb begin
      result_c  = '0;
      illegal_c = 1'b0;
      ovf_c     = 1'b0;
      case (bus.ALU_Control)
         c_op_and: result_c = bus.Op_A & bus.Op_B;
         c_op_or:  result_c = bus.Op_A | bus.Op_B;
         c_op_add: begin
            result_c = sum_c;
            ovf_c    = (bus.Op_A[DATA_W-1] == bus.Op_B[DATA_W-1]) &&
                       (sum_c[DATA_W-1] != bus.Op_A[DATA_W-1]);
         end
         c_op_sub: begin
            result_c = diff_c;
            ovf_c    = (bus.Op_A[DATA_W-1] != bus.Op_B[DATA_W-1]) &&
                       (diff_c[DATA_W-1] != bus.Op_A[DATA_W-1]);
         end
         c_op_slt: result_c = {{(DATA_W-1){1'b0}}, ($signed(bus.Op_A) < $signed(bus.Op_B))};
         default:  illegal_c = 1'b1;
      endcase
`ifndef ALU_OVERFLOW_EN
      ovf_c = 1'b0;
`endif
   end

   // Flush beats stall; on flush the data fields load anyway since nothing consumes them.
   always_comb begin
      ex_valid_d  = ex_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      illegal_d   = illegal_q;
      ovf_d       = ovf_q;
      if (bus.Flush) begin
         ex_valid_d  = 1'b0;
         reg_write_d = 1'b0;
         illegal_d   = 1'b0;
         ovf_d       = 1'b0;
         result_d    = result_c;
         zero_d      = (result_c == '0);
         rd_d        = bus.Rd_In;
      end else if (!bus.MEM_Stall) begin
         ex_valid_d  = bus.ID_Valid;
         result_d    = result_c;
         zero_d      = (result_c == '0);
         rd_d        = bus.Rd_In;
         illegal_d   = illegal_c & bus.ID_Valid;
         ovf_d       = ovf_c & bus.ID_Valid;
         reg_write_d = bus.RegWrite_In & bus.ID_Valid & ~ovf_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q  <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         illegal_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         illegal_q   <= illegal_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.ID_Ready     = ~bus.MEM_Stall;
   assign bus.EX_Valid     = ex_valid_q;
   assign bus.ALU_Result   = result_q;
   assign bus.Zero         = zero_q;
   assign bus.Rd_Out       = rd_q;
   assign bus.RegWrite_Out = reg_write_q;
   assign bus.Illegal_Op   = illegal_q;
`ifdef ALU_OVERFLOW_EN
   assign bus.Overflow     = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
// ============================================================================
// tb_alu_ex_stage : directed + random bench against a behavioural EX/MEM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_ex_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   alu_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

   alu_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model state (what the EX/MEM register should hold)
   logic        m_valid, m_zero, m_rw, m_ill, m_ovf, m_known;
   logic [31:0] m_result;
   logic [4:0]  m_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return 32'(sa + sb);
         3'd6: return 32'(sa - sb);
         3'd7: return (sa < sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_illegal(input logic [2:0] op);
      return !(op inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7});
   endfunction

   // Overflow = the true signed result does not fit in 32 bits
   function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint r;
      r = 0;
      if (op == 3'd2) r = longint'($signed(a)) + longint'($signed(b));
      else if (op == 3'd6) r = longint'($signed(a)) - longint'($signed(b));
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   task automatic model_reset();
      m_valid = 0; m_zero = 0; m_rw = 0; m_ill = 0; m_ovf = 0;
      m_result = 0; m_rd = 0; m_known = 1;
   endtask

   task automatic compare_outputs();
      check("ex_valid", 32'(bus.EX_Valid), 32'(m_valid));
      check("regwrite", 32'(bus.RegWrite_Out), 32'(m_rw));
      check("illegal", 32'(bus.Illegal_Op), 32'(m_ill));
`ifdef ALU_OVERFLOW_EN
      check("overflow", 32'(bus.Overflow), 32'(m_ovf));
`endif
      if (m_known) begin
         check("result", bus.ALU_Result, m_result);
         check("zero", 32'(bus.Zero), 32'(m_zero));
         check("rd", 32'(bus.Rd_Out), 32'(m_rd));
      end
   endtask

   task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw, input logic stall, input logic flush);
      logic ovf;
      bus.ID_Valid = v; bus.ALU_Control = op; bus.Op_A = a; bus.Op_B = b;
      bus.Rd_In = rd; bus.RegWrite_In = rw; bus.MEM_Stall = stall; bus.Flush = flush;
      #1;
      check("id_ready", 32'(bus.ID_Ready), 32'(!stall));
      @(posedge clk);
      if (flush) begin
         m_valid = 0; m_rw = 0; m_ill = 0; m_ovf = 0; m_known = 0;
      end else if (!stall) begin
`ifdef ALU_OVERFLOW_EN
         ovf = v && ref_ovf(op, a, b);
`else
         ovf = 1'b0;
`endif
         m_valid  = v;
         m_result = ref_result(op, a, b);
         m_zero   = (m_result == 0);
         m_rd     = rd;
         m_ill    = v && ref_illegal(op);
         m_ovf    = ovf;
         m_rw     = v && rw && !ovf;
         m_known  = 1;
      end
      #1;
      compare_outputs();
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      bus.ID_Valid = 0; bus.ALU_Control = 0; bus.Op_A = 0; bus.Op_B = 0;
      bus.Rd_In = 0; bus.RegWrite_In = 0; bus.MEM_Stall = 0; bus.Flush = 0;
      model_reset();
      #12;
      compare_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Ops sequence A=F0, B=F0F
      cycle(1, 3'b000, 32'h0000_00F0, 32'h0000_0F0F, 5'd1, 1, 0, 0);
      check("and_lit", bus.ALU_Result, 32'h0);
      check("and_zero", 32'(bus.Zero), 32'd1);
      cycle(1, 3'b001, 32'h0000_00F0, 32'h0000_0F0F, 5'd2, 1, 0, 0);
      check("or_lit", bus.ALU_Result, 32'h0000_0FFF);
      cycle(1, 3'b010, 32'h0000_00F0, 32'h0000_0F0F, 5'd3, 1, 0, 0);
      check("add_lit", bus.ALU_Result, 32'h0000_0FFF);
      cycle(1, 3'b110, 32'h0000_00F0, 32'h0000_0F0F, 5'd4, 1, 0, 0);
      check("sub_lit", bus.ALU_Result, 32'hFFFF_F1E1);

      // SLT signed
      cycle(1, 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5, 1, 0, 0);
      check("slt_lit", bus.ALU_Result, 32'd1);
      cycle(1, 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd6, 1, 0, 0);
      check("slt_swap", bus.ALU_Result, 32'd0);
      check("slt_zero", 32'(bus.Zero), 32'd1);

      // Stall holding ADD 5+7, then flush during stall
      cycle(1, 3'b010, 32'd5, 32'd7, 5'd7, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 3'b001, 32'hAAAA_0000, 32'h0000_5555, 5'd9, 1, 1, 0);
         check("stall_hold", bus.ALU_Result, 32'd12);
      end
      cycle(1, 3'b001, 32'hAAAA_0000, 32'h0000_5555, 5'd9, 1, 1, 1);
      check("flush_valid", 32'(bus.EX_Valid), 32'd0);
      check("flush_rw", 32'(bus.RegWrite_Out), 32'd0);

      // Illegal op and bubble
      cycle(1, 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10, 1, 0, 0);
      check("ill_flag", 32'(bus.Illegal_Op), 32'd1);
      check("ill_zero", 32'(bus.Zero), 32'd1);
      cycle(0, 3'b010, 32'd1, 32'd2, 5'd11, 1, 0, 0);
      check("bubble_rw", 32'(bus.RegWrite_Out), 32'd0);

      // Signed overflow on ADD
      cycle(1, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd12, 1, 0, 0);
      check("ovf_result", bus.ALU_Result, 32'h8000_0000);
`ifdef ALU_OVERFLOW_EN
      check("ovf_rw", 32'(bus.RegWrite_Out), 32'd0);
      check("ovf_flag", 32'(bus.Overflow), 32'd1);
`else
      check("ovf_rw", 32'(bus.RegWrite_Out), 32'd1);
`endif

      // Asynchronous reset mid-stream with a valid instruction held
      cycle(1, 3'b001, 32'h0F00_0000, 32'h0000_00F0, 5'd13, 1, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         op = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: a = 32'h7FFF_FFFF;
            1: a = 32'h8000_0000;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 4) == 0) ? a : $urandom;
         cycle($urandom_range(0, 4) != 0, op, a, b, 5'($urandom), 1'($urandom),
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
